sort4_seq_ctrl: RTL and testbench

Sequential control stage that sits directly upstream of the 4:1 16-bit word mux in the descending sorter. It accepts four words in one handshake and sorts them in place, largest first, using a fixed 6-step compare-swap sequence, one step per cycle. It then drains the result by presenting the sorted registers on the mux data inputs and stepping the mux select 0..3 under a valid/ready handshake.

---
 rtl/sort4_seq_ctrl_if.sv | 63 ++++++
 rtl/sort4_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_sort4_seq_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort4_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sort4_seq_ctrl_if
// Brief    : Load/drain handshake bundle between the 4-word sorter control
//            stage and its producer / downstream 4:1 word mux.
// Revision : 1.0 - initial release
// ============================================================================
interface sort4_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din0;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic [WIDTH-1:0] din3;
  logic [WIDTH-1:0] s0;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] s3;
  logic [1:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;

  modport master (
    output in_valid,
    output din0,
    output din1,
    output din2,
    output din3,
    output out_ready,
    input  in_ready,
    input  s0,
    input  s1,
    input  s2,
    input  s3,
    input  sel,
    input  out_valid,
    input  out_last,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  din0,
    input  din1,
    input  din2,
    input  din3,
    input  out_ready,
    output in_ready,
    output s0,
    output s1,
    output s2,
    output s3,
    output sel,
    output out_valid,
    output out_last,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/sort4_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sort4_seq_ctrl
// Brief    : Loads four words, sorts them largest-first with a fixed 6-step
//            compare-swap network, then drains them through the word mux.
//            Define SORT4_SIGNED_EN for a two's-complement compare.
// Revision : 1.0 - initial release
// ============================================================================
module sort4_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  sort4_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] C_LAST_STEP = 3'd5;
  localparam logic [1:0] C_LAST_SEL  = 2'd3;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_step;
  logic [2:0]       w_step_nxt;
  logic [1:0]       r_sel;
  logic [1:0]       w_sel_nxt;
  logic [WIDTH-1:0] r_s     [4];
  logic [WIDTH-1:0] w_s_nxt [4];

  logic [1:0]       w_lo_idx;
  logic [1:0]       w_hi_idx;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  logic             w_swap;

  // Compare-swap network: (0,1) (1,2) (2,3) (0,1) (1,2) (0,1)
  always_comb begin
    w_lo_idx = 2'd2;
    case (r_step)
      3'd0, 3'd3, 3'd5: w_lo_idx = 2'd0;
      3'd1, 3'd4:       w_lo_idx = 2'd1;
      default:          w_lo_idx = 2'd2;
    endcase
  end

  assign w_hi_idx = w_lo_idx + 2'd1;
  assign w_lo     = r_s[w_lo_idx];
  assign w_hi     = r_s[w_hi_idx];

`ifdef SORT4_SIGNED_EN
  assign w_swap = $signed(w_lo) < $signed(w_hi);
`else
  assign w_swap = w_lo < w_hi;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_sel_nxt   = r_sel;
    w_s_nxt     = r_s;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_s_nxt[0]  = bus.din0;
          w_s_nxt[1]  = bus.din1;
          w_s_nxt[2]  = bus.din2;
          w_s_nxt[3]  = bus.din3;
          w_step_nxt  = 3'd0;
          w_state_nxt = ST_SORT;
        end
      end
      ST_SORT: begin
        // Strict less-than: equal neighbours stay where they are.
        if (w_swap) begin
          w_s_nxt[w_lo_idx] = w_hi;
          w_s_nxt[w_hi_idx] = w_lo;
        end
        if (r_step == C_LAST_STEP) begin
          w_step_nxt  = 3'd0;
          w_sel_nxt   = 2'd0;
          w_state_nxt = ST_DRAIN;
        end else begin
          w_step_nxt  = r_step + 3'd1;
        end
      end
      ST_DRAIN: begin
        if (bus.out_ready) begin
          if (r_sel == C_LAST_SEL) begin
            w_sel_nxt   = 2'd0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_sel_nxt   = r_sel + 2'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_step  <= 3'd0;
      r_sel   <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        r_s[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_sel   <= w_sel_nxt;
      r_s     <= w_s_nxt;
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.out_valid = (r_state == ST_DRAIN);
  assign bus.out_last  = (r_state == ST_DRAIN) && (r_sel == C_LAST_SEL);
  assign bus.sel       = r_sel;
  assign bus.s0        = r_s[0];
  assign bus.s1        = r_s[1];
  assign bus.s2        = r_s[2];
  assign bus.s3        = r_s[3];

endmodule
`default_nettype wire

// File: tb/tb_sort4_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort4_seq_ctrl
// Brief    : Scoreboard bench for sort4_seq_ctrl; models the downstream mux.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sort4_seq_ctrl;

  typedef logic [3:0][15:0] w4_t;

  logic clk;
  logic rst;
  logic [15:0] y;

  int          n_asserts = 0;
  int          n_fail    = 0;
  int          n_xfer    = 0;
  int          exp_sel   = 0;
  logic [15:0] sb [$];

  sort4_seq_ctrl_if #(.WIDTH(16)) bus ();

  sort4_seq_ctrl #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (bus.sel)
      2'd0:    y = bus.s0;
      2'd1:    y = bus.s1;
      2'd2:    y = bus.s2;
      default: y = bus.s3;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic lt(input logic [15:0] a, input logic [15:0] b);
`ifdef SORT4_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  // Selection sort, largest first
  function automatic w4_t sort_ref(input w4_t v);
    w4_t         r;
    int          m;
    logic [15:0] t;
    r = v;
    for (int i = 0; i < 3; i++) begin
      m = i;
      for (int j = i + 1; j < 4; j++) if (lt(r[m], r[j])) m = j;
      t = r[i]; r[i] = r[m]; r[m] = t;
    end
    return r;
  endfunction

  function automatic w4_t mk(input logic [15:0] a, b, c, d);
    w4_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  // Output monitor: every accepted word is popped from the scoreboard
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_xfer++;
      check("sel", {30'd0, bus.sel}, exp_sel);
      check("out_last", {31'd0, bus.out_last}, {31'd0, exp_sel == 3});
      if (sb.size() == 0) begin
        check("sb_level", {31'd0, sb.size() != 0}, 32'd1);
      end else begin
        check("y", {16'd0, y}, {16'd0, sb.pop_front()});
      end
      exp_sel = (exp_sel + 1) % 4;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && !bus.in_ready; i++) tick();
    check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && !(bus.in_ready && sb.size() == 0); i++) tick();
    check("drain_done", {31'd0, bus.in_ready && sb.size() == 0}, 32'd1);
  endtask

  task automatic load(input w4_t d, input w4_t e, input bit lat);
    wait_ready();
    bus.din0 = d[0]; bus.din1 = d[1]; bus.din2 = d[2]; bus.din3 = d[3];
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) sb.push_back(e[i]);
    if (lat) begin
      for (int k = 1; k <= 6; k++) begin
        check("busy_sort", {31'd0, bus.busy}, 32'd1);
        tick();
        check("lat_out_valid", {31'd0, bus.out_valid}, {31'd0, k == 6});
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_s0"}, {16'd0, bus.s0}, 32'd0);
    check({tag, "_s1"}, {16'd0, bus.s1}, 32'd0);
    check({tag, "_s2"}, {16'd0, bus.s2}, 32'd0);
    check({tag, "_s3"}, {16'd0, bus.s3}, 32'd0);
    check({tag, "_sel"}, {30'd0, bus.sel}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_out_last"}, {31'd0, bus.out_last}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    w4_t         d;
    logic [1:0]  h_sel;
    logic [15:0] h_y;
    int          base;
    int          run;
    int          g;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.din0 = '0; bus.din1 = '0; bus.din2 = '0; bus.din3 = '0;
    tick(); tick();
    check_reset_state("reset");
    rst = 1'b0;

    // Basic sort with latency and in_ready return
    load(mk(16'h0003, 16'h0009, 16'h0001, 16'h0007),
         mk(16'h0009, 16'h0007, 16'h0003, 16'h0001), 1'b1);
    tick(); tick(); tick();
    check("in_ready_last_xfer", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check("in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    check("sb_empty_basic", sb.size(), 32'd0);

    // Already sorted, then all equal
    load(mk(16'h8000, 16'h4000, 16'h0002, 16'h0001),
         mk(16'h8000, 16'h4000, 16'h0002, 16'h0001), 1'b0);
    wait_drain();
    load(mk(16'h5555, 16'h5555, 16'h5555, 16'h5555),
         mk(16'h5555, 16'h5555, 16'h5555, 16'h5555), 1'b0);
    wait_drain();

    // Backpressure
    bus.out_ready = 1'b0;
    d = mk(16'h1234, 16'hABCD, 16'h0042, 16'hFFFE);
    load(d, sort_ref(d), 1'b0);
    for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
    check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
    base  = n_xfer;
    h_sel = bus.sel;
    h_y   = y;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_sel_hold", {30'd0, bus.sel}, {30'd0, h_sel});
      check("bp_y_hold", {16'd0, y}, {16'd0, h_y});
    end
    g = 0;
    while (!bus.in_ready && g < 40) begin
      bus.out_ready = 1'b1; tick();
      bus.out_ready = 1'b0; tick();
      g++;
    end
    check("bp_xfer_count", n_xfer - base, 32'd4);
    bus.out_ready = 1'b1;
    wait_drain();

    // Reset during SORT step 3
    d = mk(16'h0010, 16'h0020, 16'h0030, 16'h0040);
    load(d, sort_ref(d), 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    sb.delete();
    exp_sel = 0;
    tick();
    rst = 1'b0;
    check_reset_state("rst_sort");
    d = mk(16'h0002, 16'h0004, 16'h0003, 16'h0001);
    load(d, mk(16'h0004, 16'h0003, 16'h0002, 16'h0001), 1'b0);
    wait_drain();

    // Reset during DRAIN at sel==2
    d = mk(16'h0100, 16'h0300, 16'h0200, 16'h0400);
    load(d, sort_ref(d), 1'b0);
    for (int i = 0; i < 20 && !(bus.out_valid && bus.sel == 2'd2); i++) tick();
    check("drain_sel2", {30'd0, bus.sel}, 32'd2);
    rst = 1'b1;
    sb.delete();
    exp_sel = 0;
    tick();
    rst = 1'b0;
    check_reset_state("rst_drain");
    d = mk(16'h0007, 16'h0005, 16'h0009, 16'h0006);
    load(d, mk(16'h0009, 16'h0007, 16'h0006, 16'h0005), 1'b0);
    wait_drain();

    // Load gating with in_valid held high
    run = 0;
    base = n_xfer;
    g = 0;
    for (int c = 0; c < 40; c++) begin
      d = mk(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      bus.din0 = d[0]; bus.din1 = d[1]; bus.din2 = d[2]; bus.din3 = d[3];
      bus.in_valid = 1'b1;
      if (bus.in_ready) begin
        w4_t e;
        e = sort_ref(d);
        for (int i = 0; i < 4; i++) sb.push_back(e[i]);
        g++;
      end
      if (bus.busy) begin
        run++;
      end else if (run > 0) begin
        check("busy_len", run, 32'd10);
        run = 0;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    wait_drain();
    check("gating_xfers", n_xfer - base, 4 * g);

    // Signedness
    load(mk(16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF),
`ifdef SORT4_SIGNED_EN
         mk(16'h7FFF, 16'h0001, 16'hFFFF, 16'h8000),
`else
         mk(16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001),
`endif
         1'b0);
    wait_drain();

    // A few random loads against the reference model
    for (int n = 0; n < 4; n++) begin
      d = mk(16'($urandom), 16'($urandom_range(0, 3)), 16'($urandom), 16'($urandom_range(0, 3)));
      load(d, sort_ref(d), 1'b0);
      wait_drain();
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
